// File: rtl/l2_mshr_alloc.sv
// L2 MSHR entry allocator: lowest-free-first grant, release tracking and a drain FSM.
// Define L2_MSHR_HWM_EN to add the occupancy high-water-mark register behind hwm.

`ifndef N_MSHR
`define N_MSHR 4
`endif
`ifndef MSHR_BITS
`define MSHR_BITS 2
`endif
`ifndef MSHR_BITS_P1
`define MSHR_BITS_P1 3
`endif

module l2_mshr_alloc (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_req,
  output logic                     alloc_ready,
  output logic [`MSHR_BITS-1:0]    alloc_idx,
  input  logic                     free_valid,
  input  logic [`MSHR_BITS-1:0]    free_idx,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     add_mshr_entry,
  output logic                     incr_mshr_cnt,
  output logic [`MSHR_BITS-1:0]    mshr_i,
  output logic [`N_MSHR-1:0]       valid_vec,
  output logic                     mshr_full,
  output logic                     mshr_empty,
  output logic                     err_free_invalid,
  output logic [`MSHR_BITS_P1-1:0] hwm
);

  localparam int NMshr = `N_MSHR;
  localparam int IdxW  = `MSHR_BITS;
  localparam int CntW  = `MSHR_BITS_P1;

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  state_e            state_q;
  logic              drain_done_q;
  logic [NMshr-1:0]  valid_q, valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q;
  logic              grant;
  logic              release_ok;

  // Full/empty come from the registered count so they never see same-cycle traffic.
  assign mshr_full  = (cnt_q == CntW'(NMshr));
  assign mshr_empty = (cnt_q == '0);

  // Any release blocks allocation: the downstream counter takes one update per cycle.
  assign alloc_ready    = !mshr_full && !free_valid && (state_q == StIdle);
  assign grant          = alloc_req && alloc_ready;
  assign release_ok     = free_valid && valid_q[free_idx];
  assign add_mshr_entry = grant;
  assign incr_mshr_cnt  = release_ok;
  assign mshr_i         = free_idx;
  assign valid_vec      = valid_q;
  assign drain_done     = drain_done_q;
  assign err_free_invalid = err_q;

  always_comb begin
    alloc_idx = '0;
    for (int i = NMshr - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IdxW'(i);
    end
  end

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (release_ok) begin
      valid_d[free_idx] = 1'b0;
      cnt_d             = cnt_q - CntW'(1);
    end else if (grant) begin
      valid_d[alloc_idx] = 1'b1;
      cnt_d              = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (free_valid && !valid_q[free_idx]) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (drain_req) begin
            state_q      <= mshr_empty ? StDone : StDrain;
            drain_done_q <= mshr_empty;
          end
        end
        StDrain: begin
          if (valid_q == '0) begin
            state_q      <= StDone;
            drain_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          drain_done_q <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef L2_MSHR_HWM_EN
  logic [CntW-1:0] hwm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm_q <= '0;
    end else if (cnt_q > hwm_q) begin
      hwm_q <= cnt_q;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_l2_mshr_alloc.sv
// Directed, table-driven bench for l2_mshr_alloc (N_MSHR=4) plus drain/reset/hwm sequences.

`timescale 1ns/1ps

module tb_l2_mshr_alloc;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ready;
  logic [1:0] alloc_idx;
  logic       free_valid;
  logic [1:0] free_idx;
  logic       drain_req;
  logic       drain_done;
  logic       add_mshr_entry;
  logic       incr_mshr_cnt;
  logic [1:0] mshr_i;
  logic [3:0] valid_vec;
  logic       mshr_full;
  logic       mshr_empty;
  logic       err_free_invalid;
  logic [2:0] hwm;

`ifdef L2_MSHR_HWM_EN
  localparam int HwmExp = 3;
`else
  localparam int HwmExp = 0;
`endif

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  l2_mshr_alloc dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (alloc_req),
    .alloc_ready      (alloc_ready),
    .alloc_idx        (alloc_idx),
    .free_valid       (free_valid),
    .free_idx         (free_idx),
    .drain_req        (drain_req),
    .drain_done       (drain_done),
    .add_mshr_entry   (add_mshr_entry),
    .incr_mshr_cnt    (incr_mshr_cnt),
    .mshr_i           (mshr_i),
    .valid_vec        (valid_vec),
    .mshr_full        (mshr_full),
    .mshr_empty       (mshr_empty),
    .err_free_invalid (err_free_invalid),
    .hwm              (hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       areq;
    logic       fv;
    logic [1:0] fidx;
    logic       dreq;
    logic       ready;
    logic [1:0] aidx;
    logic       add;
    logic       incr;
    logic [3:0] vv;
    logic       full;
    logic       empty;
    logic       err;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic a, logic f, logic [1:0] fi, logic d, logic r,
                              logic [1:0] ai, logic ad, logic in, logic [3:0] vv,
                              logic fu, logic em, logic er);
    vec_t v;
    v = '{areq: a, fv: f, fidx: fi, dreq: d, ready: r, aidx: ai, add: ad, incr: in,
          vv: vv, full: fu, empty: em, err: er};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic f, input logic [1:0] fi, input logic d);
    alloc_req  = a;
    free_valid = f;
    free_idx   = fi;
    drain_req  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " valid_vec"}, int'(valid_vec), 0);
    chk({tag, " mshr_empty"}, int'(mshr_empty), 1);
    chk({tag, " mshr_full"}, int'(mshr_full), 0);
    chk({tag, " drain_done"}, int'(drain_done), 0);
    chk({tag, " err"}, int'(err_free_invalid), 0);
    chk({tag, " hwm"}, int'(hwm), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    // Fill: alloc x4, overflow, release/re-alloc, release+alloc collision, invalid release.
    vecs[0]  = mk(H, L, 2'd0, L, H, 2'd0, H, L, 4'b0000, L, H, L);
    vecs[1]  = mk(H, L, 2'd0, L, H, 2'd1, H, L, 4'b0001, L, L, L);
    vecs[2]  = mk(H, L, 2'd0, L, H, 2'd2, H, L, 4'b0011, L, L, L);
    vecs[3]  = mk(H, L, 2'd0, L, H, 2'd3, H, L, 4'b0111, L, L, L);
    vecs[4]  = mk(H, L, 2'd0, L, L, 2'd0, L, L, 4'b1111, H, L, L);
    vecs[5]  = mk(L, H, 2'd2, L, L, 2'd0, L, H, 4'b1111, H, L, L);
    vecs[6]  = mk(H, L, 2'd0, L, H, 2'd2, H, L, 4'b1011, L, L, L);
    vecs[7]  = mk(L, H, 2'd0, L, L, 2'd0, L, H, 4'b1111, H, L, L);
    vecs[8]  = mk(H, H, 2'd1, L, L, 2'd0, L, H, 4'b1110, L, L, L);
    vecs[9]  = mk(H, L, 2'd0, L, H, 2'd0, H, L, 4'b1100, L, L, L);
    vecs[10] = mk(L, H, 2'd3, L, L, 2'd0, L, H, 4'b1101, L, L, L);
    vecs[11] = mk(L, H, 2'd3, L, L, 2'd0, L, L, 4'b0101, L, L, L);
    vecs[12] = mk(L, L, 2'd0, L, H, 2'd1, L, L, 4'b0101, L, L, H);
    vecs[13] = mk(L, H, 2'd0, L, L, 2'd0, L, H, 4'b0101, L, L, H);
    vecs[14] = mk(L, H, 2'd2, L, L, 2'd0, L, H, 4'b0100, L, L, H);
    vecs[15] = mk(L, L, 2'd0, L, H, 2'd0, L, L, 4'b0000, L, H, H);

    rst = 1'b0;
    drive(L, L, 2'd0, L);
    #2;
    chk_reset_vals("reset");
    #10;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].areq, vecs[i].fv, vecs[i].fidx, vecs[i].dreq);
      #1;
      chk($sformatf("vec%0d alloc_ready", i), int'(alloc_ready), int'(vecs[i].ready));
      if (vecs[i].ready)
        chk($sformatf("vec%0d alloc_idx", i), int'(alloc_idx), int'(vecs[i].aidx));
      chk($sformatf("vec%0d add", i), int'(add_mshr_entry), int'(vecs[i].add));
      chk($sformatf("vec%0d incr", i), int'(incr_mshr_cnt), int'(vecs[i].incr));
      if (vecs[i].fv)
        chk($sformatf("vec%0d mshr_i", i), int'(mshr_i), int'(vecs[i].fidx));
      chk($sformatf("vec%0d valid_vec", i), int'(valid_vec), int'(vecs[i].vv));
      chk($sformatf("vec%0d full", i), int'(mshr_full), int'(vecs[i].full));
      chk($sformatf("vec%0d empty", i), int'(mshr_empty), int'(vecs[i].empty));
      chk($sformatf("vec%0d err", i), int'(err_free_invalid), int'(vecs[i].err));
      chk($sformatf("vec%0d drain_done", i), int'(drain_done), 0);
      tick();
    end

    // Drain with two live entries; drain_req dropped after one cycle.
    drive(H, L, 2'd0, L); tick();
    drive(H, L, 2'd0, L); tick();
    chk("drain pre valid_vec", int'(valid_vec), 3);
    drive(L, L, 2'd0, H); #1;
    chk("drain req cycle done", int'(drain_done), 0);
    tick();
    drive(H, L, 2'd0, L); #1;
    chk("drain blocks ready", int'(alloc_ready), 0);
    chk("drain blocks add", int'(add_mshr_entry), 0);
    tick();
    drive(H, H, 2'd0, L); #1;
    chk("drain free0 incr", int'(incr_mshr_cnt), 1);
    chk("drain free0 ready", int'(alloc_ready), 0);
    tick();
    drive(H, H, 2'd1, L); #1;
    chk("drain free1 incr", int'(incr_mshr_cnt), 1);
    tick();
    drive(L, L, 2'd0, L);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (drain_done) dcnt++;
      tick();
    end
    chk("drain_done pulse count", dcnt, 1);
    chk("post drain ready", int'(alloc_ready), 1);
    chk("post drain valid_vec", int'(valid_vec), 0);

    // Drain on an empty MSHR completes on the next cycle.
    drive(L, L, 2'd0, H); tick();
    drive(L, L, 2'd0, L); #1;
    chk("empty drain done", int'(drain_done), 1);
    chk("empty drain ready", int'(alloc_ready), 0);
    tick(); #1;
    chk("empty drain done clears", int'(drain_done), 0);

    // Asynchronous reset in the middle of a drain.
    drive(H, L, 2'd0, L); tick();
    drive(H, L, 2'd0, L); tick();
    drive(L, L, 2'd0, H); tick();
    drive(L, L, 2'd0, L);
    #2;
    chk("mid-drain pre-reset valid_vec", int'(valid_vec), 3);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid-drain reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // High-water mark: allocate 3, free 3, allocate 1.
    for (int k = 0; k < 3; k++) begin
      drive(H, L, 2'd0, L); tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(L, H, 2'(k), L); tick();
    end
    drive(H, L, 2'd0, L); tick();
    drive(L, L, 2'd0, L); tick(); #1;
    chk("hwm after 3/3/1", int'(hwm), HwmExp);
    chk("hwm seq valid_vec", int'(valid_vec), 1);

    // Asynchronous reset during a grant.
    drive(H, L, 2'd0, L); tick();
    drive(H, L, 2'd0, L);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("mid-grant reset");
    drive(L, L, 2'd0, L);
    @(negedge clk);
    rst = 1'b1;
    tick(); #1;
    chk("after reset empty", int'(mshr_empty), 1);
    chk("after reset ready", int'(alloc_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
